controlador_cache: RTL

Sequencing controller between a requester and the cache/main-memory datapath (L1 cache block plus synchronous main memory, 5-bit addresses, 8-bit data). It accepts one read or write request at a time, checks the cache, and on a miss runs the write-back-then-fill sequence: dirty victim to main memory, line fetched from main memory, line installed in the cache. It then returns one response pulse. It also keeps saturating hit, miss and write-back counters for the board displays.

---
 rtl/controlador_cache.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/controlador_cache.sv
// controlador_cache: sequences one read/write request at a time through
// cache lookup, optional dirty write-back, line fill from main memory and
// line update, then returns a single response pulse. Also keeps saturating
// hit/miss/write-back counters for the board displays.
module controlador_cache #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 8
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              req_in,
  input  logic              wren_in,
  input  logic [ADDR_W-1:0] endereco_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              pronto_out,
  output logic [DATA_W-1:0] q_out,
  output logic              hit_out,
  output logic              ocupado_out,
  input  logic              cache_hit_in,
  input  logic              cache_dirty_in,
  input  logic [ADDR_W-1:0] cache_tag_dirty_in,
  input  logic [DATA_W-1:0] cache_q_in,
  output logic [ADDR_W-1:0] cache_endereco_out,
  output logic              cache_wren_out,
  output logic              cache_fill_out,
  output logic [DATA_W-1:0] cache_data_out,
  output logic              mem_wren_out,
  output logic [ADDR_W-1:0] mem_endereco_out,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_q_in,
  output logic [CNT_W-1:0]  hit_count_out,
  output logic [CNT_W-1:0]  miss_count_out,
  output logic [CNT_W-1:0]  wb_count_out
);

  // Three bits cover the legal memory latency range of 1..7
  localparam int LAT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL,
    UPDATE,
    RESPOND
  } state_t;

  state_t state;
  state_t next_state;

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_wren;
  logic              was_hit;
  logic [ADDR_W-1:0] victim_addr;
  logic [DATA_W-1:0] victim_data;
  logic [DATA_W-1:0] fetched;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] q_next;
  logic              hit_next;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // State register; reset aborts any sequence in flight
  always_ff @(posedge clock_in) begin
    if (reset_in) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state decision for the lookup / write-back / fill / update sequence
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (req_in) next_state = LOOKUP;
      LOOKUP: begin
        if (cache_hit_in)        next_state = req_wren ? UPDATE : RESPOND;
        else if (cache_dirty_in) next_state = WRITEBACK;
        else                     next_state = FILL;
      end
      WRITEBACK: next_state = FILL;
      FILL:      if (lat_cnt == LAT_W'(1)) next_state = UPDATE;
      UPDATE:    next_state = RESPOND;
      RESPOND:   next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Strobes and buses toward the cache and main memory, decoded from state
  always_comb begin
    pronto_out       = 1'b0;
    ocupado_out      = (state != IDLE);
    cache_wren_out   = 1'b0;
    cache_fill_out   = 1'b0;
    cache_data_out   = '0;
    mem_wren_out     = 1'b0;
    mem_endereco_out = req_addr;
    mem_data_out     = '0;
    case (state)
      WRITEBACK: begin
        mem_wren_out     = 1'b1;
        mem_endereco_out = victim_addr;
        mem_data_out     = victim_data;
      end
      UPDATE: begin
        if (was_hit) begin
          cache_wren_out = 1'b1;
          cache_data_out = req_data;
        end else if (req_wren) begin
          cache_fill_out = 1'b1;
          cache_wren_out = 1'b1;
          cache_data_out = req_data;
        end else begin
          cache_fill_out = 1'b1;
          cache_data_out = fetched;
        end
      end
      RESPOND: pronto_out = 1'b1;
      default: ;
    endcase
  end

  assign cache_endereco_out = req_addr;

  // Response value presented with the pronto pulse: read hits forward the
  // cache data straight from lookup, writes echo the written data
  always_comb begin
    q_next   = req_wren ? req_data : fetched;
    hit_next = was_hit;
    if (state == LOOKUP) begin
      q_next   = cache_q_in;
      hit_next = 1'b1;
    end
  end

  // Request latch, victim capture, fill latency counter and response registers
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      req_addr    <= '0;
      req_data    <= '0;
      req_wren    <= 1'b0;
      was_hit     <= 1'b0;
      victim_addr <= '0;
      victim_data <= '0;
      fetched     <= '0;
      lat_cnt     <= '0;
      q_out       <= '0;
      hit_out     <= 1'b0;
    end else begin
      if (state == IDLE && req_in) begin
        req_addr <= endereco_in;
        req_data <= data_in;
        req_wren <= wren_in;
      end
      if (state == LOOKUP) begin
        was_hit <= cache_hit_in;
        if (!cache_hit_in && cache_dirty_in) begin
          victim_addr <= cache_tag_dirty_in;
          victim_data <= cache_q_in;
        end
      end
      if (state != FILL && next_state == FILL) begin
        lat_cnt <= LAT_W'(MEM_LATENCY);
      end else if (state == FILL) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
        if (lat_cnt == LAT_W'(1)) fetched <= mem_q_in;
      end
      if (next_state == RESPOND) begin
        q_out   <= q_next;
        hit_out <= hit_next;
      end
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      hit_count_out  <= '0;
      miss_count_out <= '0;
      wb_count_out   <= '0;
    end else begin
      if (state == LOOKUP) begin
        if (cache_hit_in) begin
          if (hit_count_out != CNT_MAX) hit_count_out <= hit_count_out + 1'b1;
        end else begin
          if (miss_count_out != CNT_MAX) miss_count_out <= miss_count_out + 1'b1;
        end
      end
      if (state == WRITEBACK && wb_count_out != CNT_MAX) begin
        wb_count_out <= wb_count_out + 1'b1;
      end
    end
  end

endmodule
